// File: rtl/password_checker_pkg.sv
// Shared types and key codes for the keypad password checker.
// Anything consuming the keypad scanner can import this package.
package pw_pkg;

  typedef enum logic [2:0] {
    ENTRY = 3'd0,
    CHECK = 3'd1,
    OPEN  = 3'd2,
    FAIL  = 3'd3,
    LOCK  = 3'd4
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  function automatic logic is_digit(input logic [3:0] v);
    return v < 4'd10;
  endfunction

endpackage

// File: rtl/password_checker_if.sv
// Keypad-side inputs and door/display-side outputs of the password checker.
// The bench drives through master; the checker uses slave.
interface password_checker_if #(
  parameter int DIGITS = 4
);
  logic [3:0]          value;
  logic                enable;
  logic                unlock;
  logic                error;
  logic                locked;
  logic [3:0]          digit_count;
  logic [4*DIGITS-1:0] entry;
  logic [2:0]          fail_count;

  modport master (
    output value, enable,
    input  unlock, error, locked, digit_count, entry, fail_count
  );

  modport slave (
    input  value, enable,
    output unlock, error, locked, digit_count, entry, fail_count
  );
endinterface

// File: rtl/password_checker_key_event.sv
// Turns the keypad's level-style enable into one event per key press.
// A key still held when reset releases is not treated as a fresh press.
module key_event (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] value,
  output logic       key_ev,
  output logic [3:0] key_val
);

  logic enable_d_q, enable_d_d;
  logic armed_q, armed_d;

  always_comb begin
    enable_d_d = enable;
    armed_d    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      enable_d_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      enable_d_q <= enable_d_d;
      armed_q    <= armed_d;
    end
  end

  assign key_ev  = enable & ~enable_d_q & armed_q;
  assign key_val = value;

endmodule

// File: rtl/password_checker.sv
// Keypad code lock: buffers BCD digits, checks them on ENTER and drives
// timed unlock / error / lockout indications.
module password_checker
  import pw_pkg::*;
#(
  parameter int                  DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] PASSWORD    = 16'h1234,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  OPEN_CYCLES = 100,
  parameter int                  ERR_CYCLES  = 50,
  parameter int                  LOCK_CYCLES = 500
) (
  input logic clk,
  input logic rst,
  password_checker_if.slave bus
);

  localparam int EW   = 4 * DIGITS;
  localparam int TMAX = (OPEN_CYCLES > ERR_CYCLES)
                        ? ((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES)
                        : ((ERR_CYCLES > LOCK_CYCLES) ? ERR_CYCLES : LOCK_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic       key_ev;
  logic [3:0] key_val;

  key_event u_key_event (
    .clk    (clk),
    .rst    (rst),
    .enable (bus.enable),
    .value  (bus.value),
    .key_ev (key_ev),
    .key_val(key_val)
  );

  state_t          state_q, state_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            match;
  logic            timer_done;
  logic            clear_ev;

  assign match    = (cnt_q == 4'(DIGITS)) && (entry_q == PASSWORD);
  assign clear_ev = key_ev && (key_val == KEY_CLEAR);

  always_comb begin
    timer_done = 1'b0;
    case (state_q)
      OPEN:    timer_done = (timer_q == TW'(OPEN_CYCLES - 1));
      FAIL:    timer_done = (timer_q == TW'(ERR_CYCLES - 1));
      LOCK:    timer_done = (timer_q == TW'(LOCK_CYCLES - 1));
      default: timer_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    case (state_q)
      ENTRY: begin
        if (key_ev) begin
          if (is_digit(key_val)) begin
            // A full buffer silently drops further digits.
            if (cnt_q < 4'(DIGITS)) begin
              entry_d = (entry_q << 4) | EW'(key_val);
              cnt_d   = cnt_q + 4'd1;
            end
          end else if (key_val == KEY_CLEAR) begin
            entry_d = '0;
            cnt_d   = 4'd0;
          end else if (key_val == KEY_ENTER) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        entry_d = '0;
        cnt_d   = 4'd0;
        timer_d = '0;
        if (match) begin
          state_d = OPEN;
          fail_d  = 3'd0;
        end else if (fail_q == 3'(MAX_FAIL - 1)) begin
          state_d = LOCK;
          fail_d  = 3'd0;
        end else begin
          state_d = FAIL;
          fail_d  = fail_q + 3'd1;
        end
      end
      OPEN, FAIL, LOCK: begin
        // Only an open door can be closed early with CLEAR.
        if (timer_done || (state_q == OPEN && clear_ev)) begin
          state_d = ENTRY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ENTRY;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ENTRY;
      entry_q <= '0;
      cnt_q   <= 4'd0;
      fail_q  <= 3'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
    end
  end

  assign bus.unlock      = (state_q == OPEN);
  assign bus.error       = (state_q == FAIL);
  assign bus.locked      = (state_q == LOCK);
  assign bus.digit_count = cnt_q;
  assign bus.entry       = entry_q;
  assign bus.fail_count  = fail_q;

endmodule

// File: tb/tb_password_checker.sv
// Directed and randomized bench for password_checker, checked against a
// queue-based model of the code entry and failure/lockout rules.
module tb_password_checker;

  localparam int DIGITS      = 4;
  localparam int PASSWORD    = 'h1234;
  localparam int MAX_FAIL    = 3;
  localparam int OPEN_CYCLES = 100;
  localparam int ERR_CYCLES  = 50;
  localparam int LOCK_CYCLES = 500;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  password_checker_if #(.DIGITS(DIGITS)) bus ();

  password_checker #(
    .DIGITS     (DIGITS),
    .PASSWORD   (16'h1234),
    .MAX_FAIL   (MAX_FAIL),
    .OPEN_CYCLES(OPEN_CYCLES),
    .ERR_CYCLES (ERR_CYCLES),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int passed = 0;
  int total  = 0;

  // Model: digits accepted so far, and consecutive failures.
  int mq[$];
  int m_fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int model_code();
    int c = 0;
    foreach (mq[i]) c = c * 16 + mq[i];
    return c;
  endfunction

  function automatic void model_key(input int key);
    if (key < 10) begin
      if (mq.size() < DIGITS) mq.push_back(key);
    end else if (key == 10) begin
      mq.delete();
    end
  endfunction

  function automatic logic [2:0] outs();
    return {bus.unlock, bus.error, bus.locked};
  endfunction

  task automatic press(input int key, input int hold, input int gap, input bit apply);
    @(negedge clk);
    bus.value  = 4'(key);
    bus.enable = 1'b1;
    repeat (hold) @(negedge clk);
    bus.enable = 1'b0;
    repeat (gap) @(negedge clk);
    if (apply) model_key(key);
  endtask

  task automatic press_checked(input int key, input int hold, input int gap);
    press(key, hold, gap, 1'b1);
    check("digit_count", 32'(bus.digit_count), 32'(mq.size()));
    check("entry", 32'(bus.entry), 32'(model_code()));
  endtask

  // Press ENTER, check the idle CHECK cycle and the first outcome cycle.
  task automatic do_enter(output logic [2:0] exp_o, output int exp_len);
    bit match;
    match = (mq.size() == DIGITS) && (model_code() == PASSWORD);
    if (match) begin
      exp_o = 3'b100; exp_len = OPEN_CYCLES; m_fails = 0;
    end else if (m_fails == MAX_FAIL - 1) begin
      exp_o = 3'b001; exp_len = LOCK_CYCLES; m_fails = 0;
    end else begin
      exp_o = 3'b010; exp_len = ERR_CYCLES; m_fails++;
    end
    $display("enter: digits=%0d code=%0h expect outs=%b len=%0d fails=%0d",
             mq.size(), model_code(), exp_o, exp_len, m_fails);
    mq.delete();
    @(negedge clk);
    bus.value  = 4'd11;
    bus.enable = 1'b1;
    @(negedge clk);
    check("check_cycle_outs", 32'(outs()), 32'd0);
    bus.enable = 1'b0;
    @(negedge clk);
    check("outcome_outs", 32'(outs()), 32'(exp_o));
    check("fail_count", 32'(bus.fail_count), 32'(m_fails));
  endtask

  // Count how long the indication stays high (first cycle already seen).
  task automatic measure(input int exp_len);
    int cnt = 1;
    int guard = 0;
    while (outs() != 3'b000 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (outs() != 3'b000) cnt++;
    end
    check("pulse_len", 32'(cnt), 32'(exp_len));
    check("idle_digits", 32'(bus.digit_count), 32'd0);
    check("idle_entry", 32'(bus.entry), 32'd0);
  endtask

  initial begin
    logic [2:0] eo;
    int el;
    int n, k;

    bus.value  = 4'd0;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'(outs()), 32'd0);
    check("rst_digits", 32'(bus.digit_count), 32'd0);
    check("rst_fail", 32'(bus.fail_count), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Correct code
    press_checked(1, 5, 5); press_checked(2, 5, 5);
    press_checked(3, 5, 5); press_checked(4, 5, 5);
    do_enter(eo, el); measure(el);

    // Held key: one event only
    press_checked(7, 20, 5);
    check("held_lsb", 32'(bus.entry[3:0]), 32'd7);
    press_checked(10, 3, 3);

    // Overflow digit ignored
    press_checked(1, 2, 2); press_checked(2, 2, 2); press_checked(3, 2, 2);
    press_checked(4, 2, 2); press_checked(5, 2, 2);
    check("overflow_entry", 32'(bus.entry), 32'h1234);
    do_enter(eo, el); measure(el);

    // Clear mid-entry leaves 2 digits -> mismatch
    press_checked(1, 3, 3); press_checked(2, 3, 3); press_checked(10, 3, 3);
    press_checked(3, 3, 3); press_checked(4, 3, 3);
    do_enter(eo, el); measure(el);

    // Early exit from OPEN with CLEAR
    press_checked(1, 2, 2); press_checked(2, 2, 2);
    press_checked(3, 2, 2); press_checked(4, 2, 2);
    do_enter(eo, el);
    repeat (8) @(negedge clk);
    check("open_before_clear", 32'(bus.unlock), 32'd1);
    bus.value  = 4'd10;
    bus.enable = 1'b1;
    @(negedge clk);
    check("open_after_clear", 32'(outs()), 32'd0);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);

    // Three wrong codes; digits pressed during LOCK are ignored
    for (int a = 0; a < MAX_FAIL; a++) begin
      press_checked(1, 2, 2); press_checked(2, 2, 2);
      press_checked(3, 2, 2); press_checked(5, 2, 2);
      do_enter(eo, el);
      if (eo == 3'b001) begin
        fork
          measure(el);
          begin
            press(6, 2, 3, 1'b0); press(7, 2, 3, 1'b0); press(8, 2, 3, 1'b0);
            check("lock_digits", 32'(bus.digit_count), 32'd0);
          end
        join
      end else begin
        measure(el);
      end
    end

    // Randomized attempts
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        press_checked(1, 1, 1); press_checked(2, 1, 1);
        press_checked(3, 1, 1); press_checked(4, 1, 1);
      end else begin
        n = $urandom_range(0, 6);
        for (int j = 0; j < n; j++) begin
          k = $urandom_range(0, 15);
          if (k == 11) k = 10;
          press_checked(k, $urandom_range(1, 4), $urandom_range(1, 3));
        end
      end
      do_enter(eo, el); measure(el);
    end

    // Reset in the middle of LOCK
    for (int a = 0; a < MAX_FAIL; a++) begin
      press_checked(9, 2, 2);
      do_enter(eo, el);
      if (eo == 3'b001) break;
      measure(el);
    end
    check("reached_lock", 32'(bus.locked), 32'd1);
    repeat (198) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_fails = 0;
    mq.delete();
    check("rst_lock_outs", 32'(outs()), 32'd0);
    check("rst_lock_fail", 32'(bus.fail_count), 32'd0);
    check("rst_lock_digits", 32'(bus.digit_count), 32'd0);
    check("rst_lock_entry", 32'(bus.entry), 32'd0);

    // Key held across reset release produces no event
    @(negedge clk);
    rst        = 1'b0;
    bus.value  = 4'd5;
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check("held_thru_rst", 32'(bus.digit_count), 32'd0);
    press_checked(5, 2, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
